spi_slave_byte_io: RTL and testbench

SPI slave byte front-end between the MCU SPI pins and fabric logic. It replaces a free-running number source with a FIFO-fed transmit path: fabric pushes bytes over valid/ready, and the block serialises them MSB-first onto MISO. It also deserialises MOSI into bytes. Everything runs in the `clk_50mhz` domain; the SPI pins are oversampled through synchronisers.

---
 rtl/spi_slave_byte_io.sv | 143 ++++++++++++++
 tb/tb_spi_slave_byte_io.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_byte_io.sv
// spi_slave_byte_io: SPI mode-0 slave byte front-end, fully in the clk_50mhz domain.
//   - Fabric pushes TX bytes into a FIFO (tx_data/tx_valid/tx_ready); the shifter
//     is loaded from the FIFO head at CS assert and at every byte boundary, and
//     shifts MSB-first onto spi_miso on SCK falls. An empty FIFO sends FILL and
//     pulses tx_underrun.
//   - MOSI is sampled on SCK rises and assembled into rx_data, with a one-cycle
//     rx_valid pulse per completed byte.
// Ports:
//   clk_50mhz, rst_n            clock, async active-low reset
//   spi_clk/spi_cs_n/spi_mosi   raw SPI pins (asynchronous)
//   spi_miso, spi_miso_oe       MISO data and output enable
//   tx_data/tx_valid/tx_ready   TX byte push interface
//   rx_data/rx_valid            received byte and its update pulse
//   tx_underrun                 FILL was loaded instead of FIFO data
//   fifo_level                  TX FIFO occupancy, 0..DEPTH
module spi_slave_byte_io #(
  parameter int         DEPTH = 16,
  parameter logic [7:0] FILL  = 8'h00
) (
  input  logic                   clk_50mhz,
  input  logic                   rst_n,
  input  logic                   spi_clk,
  input  logic                   spi_cs_n,
  input  logic                   spi_mosi,
  output logic                   spi_miso,
  output logic                   spi_miso_oe,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  output logic                   tx_underrun,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // [0],[1] are the two sync flops, [2] is edge history
  logic [2:0] sck_sr, cs_sr;
  logic [1:0] mosi_sr;

  // registered edge detection; mosi_d travels alongside so it matches rise_evt
  logic rise_evt, fall_evt, cs_evt, cs_hi, mosi_d;

  logic [2:0]  bit_cnt;
  logic [7:0]  rx_shift, shifter;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop, load;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sck_sr  <= 3'b000;
      cs_sr   <= 3'b111;
      mosi_sr <= 2'b00;
    end else begin
      sck_sr  <= {sck_sr[1:0], spi_clk};
      cs_sr   <= {cs_sr[1:0], spi_cs_n};
      mosi_sr <= {mosi_sr[0], spi_mosi};
    end
  end

  // SCK edges are only meaningful while synchronised CS is low
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
      cs_evt   <= 1'b0;
      cs_hi    <= 1'b1;
      mosi_d   <= 1'b0;
    end else begin
      rise_evt <= sck_sr[1] & ~sck_sr[2] & ~cs_sr[1];
      fall_evt <= ~sck_sr[1] & sck_sr[2] & ~cs_sr[1];
      cs_evt   <= ~cs_sr[1] & cs_sr[2];
      cs_hi    <= cs_sr[1];
      mosi_d   <= mosi_sr[1];
    end
  end

  assign spi_miso_oe = ~cs_sr[1];
  assign spi_miso    = shifter[7];

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tx_ready   = ~full;
  assign fifo_level = wr_ptr - rd_ptr;
  assign push       = tx_valid & ~full;
  // fall with bit_cnt==0 follows the 8th rise of a byte
  assign load       = cs_evt | (fall_evt & (bit_cnt == 3'd0));
  // no bypass: emptiness is judged before this cycle's push lands
  assign pop        = load & ~empty;

  always_ff @(posedge clk_50mhz) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // TX shifter; a byte popped here is gone even if CS is dropped mid-byte
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      shifter     <= 8'h00;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= load & empty;
      if (load)          shifter <= empty ? FILL : mem[rd_ptr[AW-1:0]];
      else if (fall_evt) shifter <= {shifter[6:0], 1'b0};
    end
  end

  // RX path and bit counter
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (cs_hi || cs_evt) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 8'h00;
      end else if (rise_evt) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= {rx_shift[6:0], mosi_d};
        if (bit_cnt == 3'd7) begin
          rx_data  <= {rx_shift[6:0], mosi_d};
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_byte_io.sv
// Bench for spi_slave_byte_io: byte-level model (FIFO as a queue, expected RX
// bytes as a queue, expected MISO byte per bit slot) driven by directed and
// random SPI frames.
module tb_spi_slave_byte_io;
  localparam int         DEPTH = 16;
  localparam logic [7:0] FILL  = 8'hFF;
  localparam int         HALF  = 12;   // SCK half period in clk cycles (~2 MHz)
  localparam int         LW    = $clog2(DEPTH) + 1;

  logic          clk_50mhz = 1'b0;
  logic          rst_n = 1'b1;
  logic          spi_clk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic          spi_miso, spi_miso_oe;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid, tx_underrun;
  logic [LW-1:0] fifo_level;

  spi_slave_byte_io #(.DEPTH(DEPTH), .FILL(FILL)) dut (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .fifo_level(fifo_level)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  int checks = 0, errors = 0;

  // model state
  logic [7:0] q[$];        // TX FIFO contents
  logic [7:0] exp_rx[$];   // RX bytes still owed by the DUT
  logic [7:0] cur;         // byte the MCU should be reading now
  logic [7:0] rx_acc;
  int         bitpos;
  int         exp_und = 0, und_seen = 0, rx_seen = 0;
  bit         quiet = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load_next();
    if (q.size() > 0) cur = q.pop_front();
    else begin
      cur = FILL;
      exp_und++;
    end
  endtask

  // compare process
  always @(negedge clk_50mhz) begin
    if (rst_n) begin
      if (rx_valid) begin
        rx_seen++;
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_extra actual=%0h required=no pulse", rx_data);
        end else chk("rx_data", rx_data, exp_rx.pop_front());
      end
      if (tx_underrun) und_seen++;
      if (quiet) begin
        chk("fifo_level", fifo_level, q.size());
        chk("tx_ready", tx_ready, q.size() != DEPTH);
      end
    end
  end

  task automatic push(input logic [7:0] d);
    @(negedge clk_50mhz);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk_50mhz);
    if (q.size() < DEPTH) q.push_back(d);
    #1 tx_valid = 1'b0;
  endtask

  task automatic hold_push(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50mhz);
      tx_valid = 1'b1;
      tx_data  = 8'($urandom);
      @(posedge clk_50mhz);
      if (q.size() < DEPTH) q.push_back(tx_data);
    end
    #1 tx_valid = 1'b0;
  endtask

  // One CS frame of nbits (1..32); CS rises together with the last SCK fall.
  task automatic frame(input int nbits, input logic [31:0] mosi_v, output logic [31:0] miso_v);
    quiet  = 1'b0;
    miso_v = '0;
    @(negedge clk_50mhz);
    spi_cs_n = 1'b0;
    load_next();
    bitpos = 0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mosi_v[nbits-1-i];
      repeat (HALF) @(negedge clk_50mhz);
      chk("miso_bit", spi_miso, cur[7-bitpos]);
      chk("miso_oe", spi_miso_oe, 1);
      miso_v = {miso_v[30:0], spi_miso};
      rx_acc = {rx_acc[6:0], spi_mosi};
      spi_clk = 1'b1;
      bitpos++;
      if (bitpos == 8) begin
        bitpos = 0;
        exp_rx.push_back(rx_acc);
      end
      repeat (HALF) @(negedge clk_50mhz);
      spi_clk = 1'b0;
      if (i == nbits - 1) spi_cs_n = 1'b1;
      else if (bitpos == 0) load_next();
    end
    repeat (8) @(negedge clk_50mhz);
    chk("miso_oe_idle", spi_miso_oe, 0);
    chk("rx_pending", exp_rx.size(), 0);
    chk("underrun_cnt", und_seen, exp_und);
    quiet = 1'b1;
  endtask

  initial begin
    logic [31:0] mv;
    int u0, r0;

    // reset state
    #2 rst_n = 1'b0;
    #5;
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_miso", spi_miso, 0);
    chk("rst_oe", spi_miso_oe, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_und", tx_underrun, 0);
    chk("rst_rxdata", rx_data, 0);
    repeat (3) @(negedge clk_50mhz);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_50mhz);
    quiet = 1'b1;

    // two queued bytes over 16 bits
    push(8'hA5);
    push(8'h3C);
    @(negedge clk_50mhz);
    chk("t1_level2", fifo_level, 2);
    u0 = und_seen;
    frame(16, $urandom, mv);
    chk("t1_miso", mv[15:0], 16'hA53C);
    chk("t1_level0", fifo_level, 0);
    chk("t1_no_und", und_seen - u0, 0);

    // empty FIFO sends FILL
    u0 = und_seen;
    frame(8, $urandom, mv);
    chk("t2_miso", mv[7:0], 8'hFF);
    chk("t2_und_once", und_seen - u0, 1);

    // MOSI bytes
    r0 = rx_seen;
    frame(16, 32'h0000_C35A, mv);
    chk("t3_rx_pulses", rx_seen - r0, 2);
    chk("t3_rx_last", rx_data, 8'h5A);

    // partial byte then new frame
    push(8'h96);
    push(8'h0F);
    r0 = rx_seen;
    frame(5, $urandom, mv);
    chk("t5_partial_miso", mv[4:0], 5'b10010);
    chk("t5_no_rxv", rx_seen - r0, 0);
    frame(8, $urandom, mv);
    chk("t5_next_byte", mv[7:0], 8'h0F);

    // reset mid-byte with 3 bytes queued
    push(8'hF0);
    push(8'h81);
    push(8'hC7);
    quiet = 1'b0;
    @(negedge clk_50mhz);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk_50mhz);
    spi_clk = 1'b1;
    repeat (HALF) @(negedge clk_50mhz);
    spi_clk = 1'b0;
    repeat (HALF) @(negedge clk_50mhz);
    spi_clk = 1'b1;
    repeat (4) @(negedge clk_50mhz);
    chk("t6_pre_miso", spi_miso, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_miso", spi_miso, 0);
    chk("t6_oe", spi_miso_oe, 0);
    chk("t6_rxv", rx_valid, 0);
    chk("t6_und", tx_underrun, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_ready", tx_ready, 1);
    spi_clk  = 1'b0;
    spi_cs_n = 1'b1;
    q.delete();
    exp_rx.delete();
    repeat (3) @(negedge clk_50mhz);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_50mhz);
    chk("t6_level_after", fifo_level, 0);
    chk("t6_ready_after", tx_ready, 1);
    quiet = 1'b1;

    // fill the FIFO by holding tx_valid
    hold_push(DEPTH + 3);
    @(negedge clk_50mhz);
    chk("t4_level_full", fifo_level, DEPTH);
    chk("t4_ready_full", tx_ready, 0);
    frame(8, $urandom, mv);
    chk("t4_ready_after", tx_ready, 1);
    chk("t4_level_after", fifo_level, DEPTH - 1);

    // random frames
    for (int r = 0; r < 30; r++) begin
      int np;
      np = $urandom_range(0, 4);
      for (int k = 0; k < np; k++) push(8'($urandom));
      frame($urandom_range(1, 24), $urandom, mv);
      repeat ($urandom_range(0, 6)) @(negedge clk_50mhz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
